conv_lane_array: RTL and testbench

- Parametrised successor of the two-kernel 3x3 convolution datapath.
- N_LANES parallel 3x3 MAC lanes share one weight set and one stream of (N_LANES+2) input rows.
- One packed result word per input column goes to an internal single-port result SRAM, sequenced by a frame FSM with base address, wrap and count.
- Host reads results back through a registered read port when the engine is idle.

---
 rtl/conv_lane_array_if.sv | 26 ++
 rtl/conv_lane_array.sv | 170 +++++++++++++++++
 tb/tb_conv_lane_array.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_lane_array_if.sv
// Column stream and result readback port of the multi-lane 3x3 convolution engine.
// The host side uses the master modport; the engine uses the slave modport.
interface conv_lane_array_if #(
  parameter int DATA_W  = 8,
  parameter int N_LANES = 2,
  parameter int RES_W   = 16,
  parameter int ADDR_W  = 11
);
  logic [(N_LANES+2)*DATA_W-1:0] rows;
  logic                          in_valid;
  logic                          in_ready;
  logic                          rd_en;
  logic [ADDR_W-1:0]             rd_addr;
  logic [N_LANES*RES_W-1:0]      rd_data;
  logic                          rd_valid;

  modport master (
    output rows, in_valid, rd_en, rd_addr,
    input  in_ready, rd_data, rd_valid
  );

  modport slave (
    input  rows, in_valid, rd_en, rd_addr,
    output in_ready, rd_data, rd_valid
  );
endinterface

// File: rtl/conv_lane_array.sv
// N_LANES parallel 3x3 MAC lanes over a shared weight set and a shared column window.
// Packed, saturated results go to an internal result SRAM under control of a frame FSM.
module conv_lane_array #(
  parameter int DATA_W    = 8,
  parameter int N_LANES   = 2,
  parameter int RES_W     = 16,
  parameter int MEM_DEPTH = 2048,
  parameter int ADDR_W    = $clog2(MEM_DEPTH),
  parameter int COL_W     = 11
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [9*DATA_W-1:0] weights,
  input  logic                cfg_load,
  input  logic                start,
  input  logic [COL_W-1:0]    num_cols,
  input  logic [ADDR_W-1:0]   base_addr,
  output logic                busy,
  output logic                done,
  output logic                sat_flag,
  output logic [ADDR_W:0]     wr_count,
  conv_lane_array_if.slave    bus
);

  localparam int N_ROWS = N_LANES + 2;
  localparam int SUM_W  = 2 * DATA_W + 4;
  localparam int WORD_W = N_LANES * RES_W;

  typedef enum logic [2:0] {IDLE, FILL, RUN, FLUSH, DONE} state_t;

  state_t              state, state_next;
  logic [DATA_W-1:0]   wgt [9];
  logic [DATA_W-1:0]   win [N_ROWS][3];
  logic [COL_W-1:0]    col_cnt;
  logic [COL_W-1:0]    num_cols_q;
  logic                flush_cnt;
  logic [ADDR_W-1:0]   wr_addr;
  logic                xfer;
  logic                start_ok;
  logic                rd_ok;
  logic                wr_en;
  logic                win_valid;
  logic                mac_valid;
  logic                mac_sat;
  logic                mac_sat_next;
  logic [WORD_W-1:0]   mac_word;
  logic [WORD_W-1:0]   mac_word_next;
  logic [SUM_W-1:0]    acc;
  logic [WORD_W-1:0]   mem [MEM_DEPTH];

  assign bus.in_ready = (state == FILL) || (state == RUN);
  assign xfer         = bus.in_valid && bus.in_ready;
  assign start_ok     = (state == IDLE) && start && (num_cols >= COL_W'(3));
  assign busy         = (state != IDLE);
  assign done         = (state == DONE);
  assign rd_ok        = bus.rd_en && !busy;
  // The reset cycle must never commit a write, even with a result in flight.
  assign wr_en        = mac_valid && RESETn;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = FILL;
      FILL:    if (xfer && col_cnt == COL_W'(1)) state_next = RUN;
      RUN:     if (xfer && col_cnt == num_cols_q - COL_W'(1)) state_next = FLUSH;
      FLUSH:   if (flush_cnt) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mac_word_next = '0;
    mac_sat_next  = 1'b0;
    acc           = '0;
    for (int k = 0; k < N_LANES; k++) begin
      acc = '0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          acc = acc + SUM_W'(win[k+r][c]) * SUM_W'(wgt[3*r+c]);
        end
      end
      if (|(acc >> RES_W)) begin
        mac_word_next[k*RES_W +: RES_W] = '1;
        mac_sat_next                    = 1'b1;
      end else begin
        mac_word_next[k*RES_W +: RES_W] = RES_W'(acc);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state      <= IDLE;
      col_cnt    <= '0;
      num_cols_q <= '0;
      flush_cnt  <= 1'b0;
      win_valid  <= 1'b0;
      mac_valid  <= 1'b0;
      mac_word   <= '0;
      mac_sat    <= 1'b0;
      wr_addr    <= '0;
      wr_count   <= '0;
      sat_flag   <= 1'b0;
    end else begin
      state     <= state_next;
      flush_cnt <= (state == FLUSH) ? ~flush_cnt : 1'b0;
      win_valid <= xfer && (state == RUN);
      mac_valid <= win_valid;
      if (win_valid) begin
        mac_word <= mac_word_next;
        mac_sat  <= mac_sat_next;
      end
      if (start_ok) begin
        num_cols_q <= num_cols;
        col_cnt    <= '0;
        wr_addr    <= base_addr;
        wr_count   <= '0;
        sat_flag   <= 1'b0;
      end else begin
        if (xfer) col_cnt <= col_cnt + 1'b1;
        if (mac_valid) begin
          wr_addr  <= wr_addr + 1'b1;
          wr_count <= wr_count + 1'b1;
          if (mac_sat) sat_flag <= 1'b1;
        end
      end
    end
  end

  // Column window: c=0 is the oldest column, c=2 the newest.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      for (int j = 0; j < 9; j++) wgt[j] <= '0;
      for (int r = 0; r < N_ROWS; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
    end else begin
      if (state == IDLE && cfg_load) begin
        for (int j = 0; j < 9; j++) wgt[j] <= weights[j*DATA_W +: DATA_W];
      end
      if (xfer) begin
        for (int r = 0; r < N_ROWS; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= bus.rows[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  // NOTE: the result array has no reset so it maps onto SRAM; its contents survive RESETn.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= mac_word;
  end

  // Reads are only accepted while idle, so they never collide with a write.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      bus.rd_valid <= 1'b0;
      bus.rd_data  <= '0;
    end else begin
      bus.rd_valid <= rd_ok;
      if (rd_ok) bus.rd_data <= mem[bus.rd_addr];
    end
  end

endmodule

// File: tb/tb_conv_lane_array.sv
// Scoreboard bench for conv_lane_array: a bench-side model fills a result image,
// readbacks push expected words to a queue that is popped when rd_valid returns.
module tb_conv_lane_array;

  localparam int DATA_W    = 8;
  localparam int N_LANES   = 2;
  localparam int RES_W     = 16;
  localparam int MEM_DEPTH = 2048;
  localparam int ADDR_W    = 11;
  localparam int COL_W     = 11;
  localparam int N_ROWS    = N_LANES + 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [9*DATA_W-1:0] weights;
  logic                cfg_load;
  logic                start;
  logic [COL_W-1:0]    num_cols;
  logic [ADDR_W-1:0]   base_addr;
  logic                busy;
  logic                done;
  logic                sat_flag;
  logic [ADDR_W:0]     wr_count;

  conv_lane_array_if #(.DATA_W(DATA_W), .N_LANES(N_LANES), .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

  conv_lane_array #(
    .DATA_W(DATA_W), .N_LANES(N_LANES), .RES_W(RES_W),
    .MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .COL_W(COL_W)
  ) dut (
    .CLK(clk), .RESETn(rst_n), .weights(weights), .cfg_load(cfg_load),
    .start(start), .num_cols(num_cols), .base_addr(base_addr),
    .busy(busy), .done(done), .sat_flag(sat_flag), .wr_count(wr_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [MEM_DEPTH];
  logic [31:0] rd_q [$];
  logic [31:0] last_rd;
  int          m_w [9];
  int          pend_w [9];
  int          hist [N_ROWS][3];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_word(output bit sat);
    logic [31:0] w;
    int          sum;
    w   = '0;
    sat = 1'b0;
    for (int k = 0; k < N_LANES; k++) begin
      sum = 0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          sum += hist[k+r][c] * m_w[3*r+c];
      if (sum > 65535) begin
        sum = 65535;
        sat = 1'b1;
      end
      w[k*RES_W +: RES_W] = sum[15:0];
    end
    return w;
  endfunction

  task automatic drive_weights(input int val);
    for (int j = 0; j < 9; j++) begin
      pend_w[j] = (val < 0) ? int'($urandom_range(0, 255)) : val;
      weights[j*DATA_W +: DATA_W] = pend_w[j][7:0];
    end
  endtask

  task automatic load_weights();
    cfg_load = 1'b1;
    m_w      = pend_w;
    @(negedge clk);
    cfg_load = 1'b0;
  endtask

  task automatic take_read(input string tag);
    logic [31:0] e;
    e = rd_q.pop_front();
    check({tag, "_valid"}, bus.rd_valid, 1'b1);
    check({tag, "_data"}, bus.rd_data, e);
    last_rd = e;
  endtask

  task automatic do_read(input int a);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a[ADDR_W-1:0];
    rd_q.push_back(model_mem[a]);
    @(negedge clk);
    bus.rd_en = 1'b0;
    take_read($sformatf("rd%0d", a));
  endtask

  task automatic drive_column(input int pix);
    int p;
    for (int r = 0; r < N_ROWS; r++) begin
      p = (pix < 0) ? int'($urandom_range(0, 255)) : pix;
      bus.rows[r*DATA_W +: DATA_W] = p[7:0];
      hist[r][0] = hist[r][1];
      hist[r][1] = hist[r][2];
      hist[r][2] = p;
    end
    bus.in_valid = 1'b1;
  endtask

  // Every call starts right after a falling edge; all sampling is on falling edges.
  task automatic run_frame(input int base, input int n, input int pix, input bit cfg_start,
                           input int gap_at, input int gap_len, input bit mid_busy,
                           input int rd_start);
    int          addr;
    bit          exp_sat;
    bit          s;
    logic [31:0] w;
    addr      = base;
    exp_sat   = 1'b0;
    start     = 1'b1;
    num_cols  = n[COL_W-1:0];
    base_addr = base[ADDR_W-1:0];
    if (cfg_start) begin
      cfg_load = 1'b1;
      m_w      = pend_w;
    end
    if (rd_start >= 0) begin
      bus.rd_en   = 1'b1;
      bus.rd_addr = rd_start[ADDR_W-1:0];
      rd_q.push_back(model_mem[rd_start]);
    end
    @(negedge clk);
    start     = 1'b0;
    cfg_load  = 1'b0;
    bus.rd_en = 1'b0;
    if (rd_start >= 0) take_read("rd_with_start");
    check("busy_after_start", busy, 1'b1);
    check("wr_count_cleared", wr_count, 0);
    check("sat_flag_cleared", sat_flag, 1'b0);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.in_valid = 1'b0;
        repeat (gap_len) @(negedge clk);
        check("gap_no_write", wr_count, i - 2);
      end
      check("in_ready", bus.in_ready, 1'b1);
      drive_column(pix);
      if (i >= 2) begin
        w = model_word(s);
        model_mem[addr] = w;
        addr = (addr + 1) % MEM_DEPTH;
        exp_sat |= s;
      end
      if (mid_busy && i == 2) begin
        drive_weights(3);
        cfg_load    = 1'b1;
        bus.rd_en   = 1'b1;
        bus.rd_addr = '0;
      end
      @(negedge clk);
      cfg_load = 1'b0;
      if (mid_busy && i == 2) begin
        bus.rd_en = 1'b0;
        check("rd_busy_valid", bus.rd_valid, 1'b0);
        check("rd_busy_hold", bus.rd_data, last_rd);
      end
    end
    bus.in_valid = 1'b0;
    check("done_t1", done, 1'b0);
    @(negedge clk);
    check("done_t2", done, 1'b0);
    @(negedge clk);
    check("done_t3", done, 1'b1);
    check("busy_in_done", busy, 1'b1);
    @(negedge clk);
    check("done_pulse_end", done, 1'b0);
    check("busy_end", busy, 1'b0);
    check("wr_count_end", wr_count, n - 2);
    check("sat_flag_end", sat_flag, exp_sat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n        = 1'b0;
    weights      = '0;
    cfg_load     = 1'b0;
    start        = 1'b0;
    num_cols     = '0;
    base_addr    = '0;
    bus.rows     = '0;
    bus.in_valid = 1'b0;
    bus.rd_en    = 1'b0;
    bus.rd_addr  = '0;
    last_rd      = '0;
    for (int j = 0; j < 9; j++) begin
      m_w[j]    = 0;
      pend_w[j] = 0;
    end
    for (int a = 0; a < MEM_DEPTH; a++) model_mem[a] = '0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_valid", bus.rd_valid, 1'b0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_sat_flag", sat_flag, 1'b0);
    check("rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit weights and pixels: every lane sums to 9.
    drive_weights(1);
    load_weights();
    run_frame(0, 5, 1, 1'b0, -1, 0, 1'b0, -1);
    do_read(0);
    check("unit_word_const", bus.rd_data, 32'h0009_0009);
    do_read(1);
    do_read(2);

    // Full-scale weights loaded together with start: both lanes saturate.
    drive_weights(255);
    run_frame(10, 3, 255, 1'b1, -1, 0, 1'b0, -1);
    do_read(10);
    check("sat_word_const", bus.rd_data, 32'hFFFF_FFFF);

    // Address wrap with random data, plus a read issued in the start cycle.
    drive_weights(-1);
    load_weights();
    run_frame(2046, 6, -1, 1'b0, -1, 0, 1'b0, 0);
    do_read(2046);
    do_read(2047);
    do_read(0);
    do_read(1);

    // Three-cycle bubble after the third column.
    drive_weights(1);
    load_weights();
    run_frame(20, 5, 1, 1'b0, 3, 3, 1'b0, -1);
    do_read(20);
    do_read(21);
    do_read(22);
    check("gap_word_const", bus.rd_data, 32'h0009_0009);

    // Reset in the middle of a frame after four transfers.
    start     = 1'b1;
    num_cols  = 11'd6;
    base_addr = 11'd500;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_column(1);
      @(negedge clk);
    end
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_in_ready", bus.in_ready, 1'b0);
    check("midrst_wr_count", wr_count, 0);
    check("midrst_rd_data", bus.rd_data, 0);
    @(negedge clk);
    check("midrst_idle", busy, 1'b0);
    for (int j = 0; j < 9; j++) m_w[j] = 0;
    last_rd = '0;
    run_frame(100, 4, -1, 1'b0, -1, 0, 1'b0, -1);
    do_read(100);
    check("zero_w_const", bus.rd_data, 0);
    do_read(101);
    do_read(0);
    do_read(2);
    do_read(10);
    do_read(20);
    do_read(2047);

    // Read and weight load attempted while busy are both ignored.
    drive_weights(2);
    load_weights();
    run_frame(200, 4, -1, 1'b0, -1, 0, 1'b1, -1);
    run_frame(210, 3, -1, 1'b0, -1, 0, 1'b0, -1);
    do_read(200);
    do_read(201);
    do_read(210);

    // A start with fewer than three columns is ignored.
    start    = 1'b1;
    num_cols = 11'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("short_busy", busy, 1'b0);
      check("short_in_ready", bus.in_ready, 1'b0);
      check("short_wr_count", wr_count, 1);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
